// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_STEP    = 4;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO holding {pc, instr} entries for decode
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents all-zero data so decode never sees stale entries
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, imem request FSM and redirect handling feeding decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_W-1:0]     if_pc,
    output logic [OPCODE_W-1:0] if_opcode
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t              state;
    fetch_state_t              next_state;
    logic [PC_W-1:0]           fetch_pc;
    logic [PC_W-1:0]           drop_addr;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;
    logic                      pop;
    logic                      accept;
    logic                      fifo_push;
    logic [PC_W+INSTR_W-1:0]   head;

    assign pop = if_valid && if_ready;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (imem_req && !imem_ack) next_state = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_ack)            next_state = FETCH;
                else if (redirect_valid) next_state = DROP;
            end
            DROP: begin
                if (imem_ack) next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // DROP keeps presenting the abandoned address until memory retires it
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            FETCH: imem_req = (count < CNT_W'(DEPTH));
            WAIT:  imem_req = 1'b1;
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
            end
            default: imem_req = 1'b0;
        endcase
        if (reset) imem_req = 1'b0;
        accept = imem_req && imem_ack && (state != DROP) && !redirect_valid;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            if (redirect_valid)  fetch_pc <= redirect_pc;
            else if (accept)     fetch_pc <= fetch_pc + PC_W'(PC_STEP);
            if (state != DROP)   drop_addr <= fetch_pc;
        end
    end

    assign fifo_push = accept && (!full || pop);

    fetch_fifo #(
        .WIDTH (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (fifo_push),
        .wdata ({fetch_pc, imem_rdata}),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign if_valid  = !empty;
    assign if_instr  = head[INSTR_W-1:0];
    assign if_pc     = head[PC_W+INSTR_W-1:INSTR_W];
    assign if_opcode = opcode_of(if_instr);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against an in-order stream model
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [10:0] if_opcode;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(
        .PC_W     (64),
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          mem_lat = 0;
    int          mem_wait = 0;
    int          n_pops  = 0;
    bit          rand_lat = 1'b0;
    logic [63:0] exp_pc  = 64'h0;
    logic        pend    = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    logic        s_req   = 1'b0;
    logic        s_ack   = 1'b0;
    logic [63:0] s_addr  = 64'h0;

    // Program image: address 0 holds 32'hF84003E9
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ 32'hF84003E9;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Mid-cycle: memory answers, then protocol and decode-stream checks
    task automatic sample();
        logic [31:0] w;
        @(negedge CLK);
        if (imem_req && mem_wait >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_fn(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        if (pend) begin
            chk("req_held", imem_req, 1);
            chk("addr_held", imem_addr, pend_addr);
        end
        if (if_valid && if_ready) begin
            w = mem_fn(exp_pc);
            chk("pop_pc", if_pc, exp_pc);
            chk("pop_instr", if_instr, w);
            chk("pop_opcode", if_opcode, w >> 21);
            exp_pc = exp_pc + 64'd4;
            n_pops++;
        end else if (!if_valid) begin
            chk("empty_pc", if_pc, 0);
            chk("empty_instr_opc", {if_opcode, if_instr}, 0);
        end
        if (redirect_valid) exp_pc = redirect_pc;
        s_req  = imem_req;
        s_ack  = imem_ack;
        s_addr = imem_addr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        pend      = s_req && !s_ack;
        pend_addr = s_addr;
        if (s_ack) begin
            mem_wait = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end else if (s_req) begin
            mem_wait++;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        reset    = 1'b0;
        pend     = 1'b0;
        mem_wait = 0;
        exp_pc   = 64'h0;
        s_req    = 1'b0;
        s_ack    = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_opcode", if_opcode, 0);

        // zero-wait streaming
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t1_req", imem_req, 1);
            chk("t1_addr", imem_addr, 64'(4 * k));
            if (k == 0) chk("t1_empty", if_valid, 0);
            else        chk("t1_pc", if_pc, 64'(4 * (k - 1)));
            if (k == 1) chk("t1_opcode", if_opcode, 11'h7C2);
            tick();
        end

        // three-cycle memory latency
        do_reset();
        mem_lat  = 3;
        if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (k < 4) begin
                chk("t2_req", imem_req, 1);
                chk("t2_addr", imem_addr, 0);
                chk("t2_ack", imem_ack, (k == 3));
                chk("t2_novalid", if_valid, 0);
            end else if (k == 4) begin
                chk("t2_valid", if_valid, 1);
                chk("t2_pc", if_pc, 0);
            end else begin
                chk("t2_single", if_valid, 0);
            end
            tick();
        end

        // backpressure fills the FIFO
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (k >= 2) begin
                chk("t3_req_full", imem_req, 0);
                chk("t3_hold_pc", if_pc, 0);
            end
            tick();
        end
        if_ready = 1'b1;
        sample(); chk("t3_drain0", if_pc, 0); chk("t3_req_gated", imem_req, 0); tick();
        sample(); chk("t3_drain4", if_pc, 4); chk("t3_resume_req", imem_req, 1);
        chk("t3_resume_addr", imem_addr, 8); tick();
        sample(); chk("t3_next", if_pc, 8); tick();

        // redirect while a request is outstanding
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b1;
        sample(); tick();
        sample(); tick();
        if_ready = 1'b0;
        mem_lat  = 3;
        sample(); chk("t4_addr8", imem_addr, 8); chk("t4_noack", imem_ack, 0); chk("t4_head4", if_pc, 4); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        sample(); chk("t4_req_redir", imem_req, 1); tick();
        redirect_valid = 1'b0;
        sample(); chk("t4_flushed", if_valid, 0); chk("t4_drop_addr", imem_addr, 8); tick();
        sample(); chk("t4_drop_ack", imem_ack, 1); chk("t4_drop_addr2", imem_addr, 8); tick();
        mem_lat  = 0;
        if_ready = 1'b1;
        sample(); chk("t4_new_req", imem_req, 1); chk("t4_new_addr", imem_addr, 64'h100);
        chk("t4_discarded", if_valid, 0); tick();
        sample(); chk("t4_target", if_pc, 64'h100); tick();

        // redirect coinciding with ack and pop
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b1;
        sample(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        sample(); chk("t5_pop0", if_pc, 0); chk("t5_ack", imem_ack, 1); tick();
        redirect_valid = 1'b0;
        sample(); chk("t5_dropped", if_valid, 0); chk("t5_addr", imem_addr, 64'h40); tick();
        sample(); chk("t5_target", if_pc, 64'h40); tick();

        // asynchronous reset in WAIT
        do_reset();
        mem_lat  = 0;
        sample(); tick();
        mem_lat = 5;
        sample(); chk("t6_addr4", imem_addr, 4); chk("t6_noack", imem_ack, 0); tick();
        sample(); chk("t6_wait", imem_req, 1); chk("t6_valid", if_valid, 1);
        imem_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req", imem_req, 0);
        chk("t6_addr", imem_addr, 0);
        chk("t6_valid_rst", if_valid, 0);
        chk("t6_pc", if_pc, 0);
        chk("t6_instr", if_instr, 0);
        chk("t6_opcode", if_opcode, 0);
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b1;
        sample(); chk("t6_first_req", imem_req, 1); chk("t6_first_addr", imem_addr, 0); tick();
        sample(); chk("t6_first_pc", if_pc, 0); tick();

        // randomized traffic, latency and redirects (including PC wrap)
        do_reset();
        rand_lat = 1'b1;
        mem_lat  = $urandom_range(0, 3);
        n_pops   = 0;
        for (int k = 0; k < 3000; k++) begin
            if_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            else                           redirect_pc = {$urandom, $urandom} & ~64'h3;
            sample();
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", (n_pops > 500), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
